// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cnn_pkg                                                     |
// | Brief   : Shared types, constants and helpers for the CNN pipeline.   |
// | Rev     : 1.0                                                         |
// +----------------------------------------------------------------------+
package cnn_pkg;

  localparam int GAP_CH    = 128;
  localparam int GAP_HW    = 16;
  localparam int ACT_W     = 4;
  localparam int GAP_SUM_W = ACT_W + $clog2(GAP_HW);

  typedef enum logic [2:0] {
    GAP_IDLE     = 3'd0,
    GAP_UP_START = 3'd1,
    GAP_WAIT_UP  = 3'd2,
    GAP_STREAM   = 3'd3,
    GAP_DRAIN    = 3'd4,
    GAP_DONE     = 3'd5
  } gap_state_t;

  // Round-half-up mean of GAP_HW activations. The largest sum (15*16) plus
  // the half-LSB bias still fits in GAP_SUM_W bits, so no carry is lost.
  function automatic logic [ACT_W-1:0] avg_round(input logic [GAP_SUM_W-1:0] sum);
    logic [GAP_SUM_W-1:0] biased;
    biased = sum + GAP_SUM_W'(GAP_HW / 2);
    return ACT_W'(biased >> $clog2(GAP_HW));
  endfunction

endpackage
`default_nettype wire

// File: rtl/gap_accum_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : gap_accum_unit                                               |
// | Brief  : Per-channel accumulator; emits one rounded mean every HW     |
// |          samples, tagged with its channel index.                      |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module gap_accum_unit
  import cnn_pkg::*;
#(
  parameter int CH = GAP_CH,
  parameter int HW = GAP_HW,
  parameter int DW = ACT_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [DW-1:0]         sample,
  output logic                  result_valid,
  output logic [DW-1:0]         result,
  output logic [$clog2(CH)-1:0] result_ch
);

  localparam int IDX_W = $clog2(HW);
  localparam int CH_W  = $clog2(CH);
  localparam int SUM_W = DW + IDX_W;

  logic [CH_W+IDX_W-1:0] r_cnt;
  logic [SUM_W-1:0]      r_acc;
  logic [SUM_W-1:0]      w_sum;

  // Running sum including the sample arriving this cycle.
  assign w_sum = r_acc + SUM_W'(sample);

  // Accumulate samples; on the last sample of a channel publish the mean and restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
    end else if (clear) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (sample_valid) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt[IDX_W-1:0] == IDX_W'(HW - 1)) begin
          result       <= avg_round(w_sum);
          result_ch    <= r_cnt[CH_W+IDX_W-1:IDX_W];
          result_valid <= 1'b1;
          r_acc        <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/global_avgpool_4x4_128ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : global_avgpool_4x4_128ch                                     |
// | Brief  : Global average pool over 4x4x128 4-bit activations. Starts   |
// |          the upstream max-pool, streams its output, stores 128 means. |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module global_avgpool_4x4_128ch
  import cnn_pkg::*;
#(
  parameter int CH     = GAP_CH,
  parameter int HW     = GAP_HW,
  parameter int DW     = ACT_W,
  parameter int UP_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [31:0]   read_addr,
  output logic [DW-1:0] read_data,
  output logic          done,
  output logic          busy,
  output logic          up_start,
  input  logic          up_done,
  output logic [31:0]   up_read_addr,
  input  logic [DW-1:0] up_read_data
);

  localparam int          CH_W      = $clog2(CH);
  localparam logic [31:0] LAST_ADDR = 32'(CH * HW - 1);

  gap_state_t        r_state;
  logic              r_issue_valid;
  logic [UP_LAT-1:0] r_vpipe;
  logic [DW-1:0]     r_result [CH];

  logic              w_clear;
  logic              w_sample_valid;
  logic              w_res_valid;
  logic [DW-1:0]     w_res;
  logic [CH_W-1:0]   w_res_ch;
  logic              w_last_written;

  assign w_clear        = (r_state == GAP_WAIT_UP) && up_done;
  assign w_sample_valid = r_vpipe[UP_LAT-1];
  assign w_last_written = w_res_valid && (w_res_ch == CH_W'(CH - 1));

  // Sequencer: upstream handshake, contiguous address issue, completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= GAP_IDLE;
      up_start      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      up_read_addr  <= '0;
      r_issue_valid <= 1'b0;
    end else begin
      up_start <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        GAP_IDLE: begin
          if (start) begin
            up_start <= 1'b1;
            busy     <= 1'b1;
            r_state  <= GAP_UP_START;
          end
        end
        GAP_UP_START: r_state <= GAP_WAIT_UP;
        GAP_WAIT_UP: begin
          if (up_done) begin
            up_read_addr  <= '0;
            r_issue_valid <= 1'b1;
            r_state       <= GAP_STREAM;
          end
        end
        GAP_STREAM: begin
          if (up_read_addr == LAST_ADDR) begin
            r_issue_valid <= 1'b0;
            r_state       <= GAP_DRAIN;
          end else begin
            up_read_addr <= up_read_addr + 32'd1;
          end
        end
        GAP_DRAIN: begin
          // The final result is committed on this same edge.
          if ((r_vpipe == '0) && w_last_written) begin
            done    <= 1'b1;
            r_state <= GAP_DONE;
          end
        end
        GAP_DONE: begin
          busy    <= 1'b0;
          r_state <= GAP_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= GAP_IDLE;
        end
      endcase
    end
  end

  // Valid tag travelling alongside each issued address until its data returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe <= UP_LAT'({r_vpipe, r_issue_valid});
    end
  end

  gap_accum_unit #(
    .CH (CH),
    .HW (HW),
    .DW (DW)
  ) u_accum (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (w_clear),
    .sample_valid (w_sample_valid),
    .sample       (up_read_data),
    .result_valid (w_res_valid),
    .result       (w_res),
    .result_ch    (w_res_ch)
  );

  // Result register file, written once per channel as means complete.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CH; i++) begin
        r_result[i] <= '0;
      end
    end else if (w_res_valid) begin
      r_result[w_res_ch] <= w_res;
    end
  end

  assign read_data = (read_addr < 32'(CH)) ? r_result[read_addr[CH_W-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_global_avgpool_4x4_128ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_global_avgpool_4x4_128ch                                  |
// | Brief  : Bench driving three instances (UP_LAT = 1,2,3) in lockstep   |
// |          from one upstream image, scoreboarding the 128 means.        |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_global_avgpool_4x4_128ch;

  localparam int N      = 3;
  localparam int N_ELEM = 2048;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        up_done = 1'b0;
  logic [31:0] read_addr = '0;

  logic [3:0]  rd_w   [N];
  logic        done_w [N];
  logic        busy_w [N];
  logic        ups_w  [N];
  logic [31:0] upa_w  [N];
  logic [3:0]  upd_w  [N];

  logic [3:0]  up_mem [N_ELEM];

  int cyc = 0;
  int tc = 0;
  bit run_active = 1'b0;
  int done_cnt [N];
  int done_cyc [N];
  int ups_cnt  [N];
  int addr_err [N];
  int b_done   [N];
  int b_ups    [N];
  int b_err    [N];
  int n_pass = 0;
  int n_total = 0;
  int exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      logic [3:0] dpipe [gi+1];

      global_avgpool_4x4_128ch #(.UP_LAT(gi + 1)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .read_addr    (read_addr),
        .read_data    (rd_w[gi]),
        .done         (done_w[gi]),
        .busy         (busy_w[gi]),
        .up_start     (ups_w[gi]),
        .up_done      (up_done),
        .up_read_addr (upa_w[gi]),
        .up_read_data (upd_w[gi])
      );

      // Upstream read port with gi+1 cycles of latency.
      always @(posedge clk) begin
        dpipe[0] <= up_mem[upa_w[gi][10:0]];
        for (int j = 1; j < gi + 1; j++) dpipe[j] <= dpipe[j-1];
      end
      assign upd_w[gi] = dpipe[gi];
    end
  endgenerate

  // Event monitor: done pulses, up_start pulses, address contiguity.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (done_w[i]) begin
        done_cyc[i] <= cyc;
        done_cnt[i] <= done_cnt[i] + 1;
      end
      if (ups_w[i]) ups_cnt[i] <= ups_cnt[i] + 1;
      if (run_active && cyc >= tc && cyc <= tc + N_ELEM - 1 && upa_w[i] !== 32'(cyc - tc))
        addr_err[i] <= addr_err[i] + 1;
    end
  end

  function automatic int exp_avg(input int ch);
    int sum;
    sum = 0;
    for (int j = 0; j < 16; j++) sum += int'(up_mem[ch*16 + j]);
    return (sum + 8) / 16;
  endfunction

  task automatic push_expected();
    for (int ch = 0; ch < 128; ch++) exp_q.push_back(exp_avg(ch));
  endtask

  // Full run: start, upstream handshake, stream, then score timing and results.
  // spur_at > 0 injects start+up_done that many cycles into the stream;
  // abort_at > 0 asserts reset at that stream offset and returns.
  task automatic do_run(input int spur_at, input int abort_at);
    bit fin;
    int e;
    b_done = done_cnt;
    b_ups  = ups_cnt;
    b_err  = addr_err;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (ups_w[i] !== 1'b1) $display("FAIL up_start_pulse inst%0d: got %b expected 1", i, ups_w[i]);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    up_done = 1'b1;
    @(posedge clk);
    #1 tc = cyc;
    run_active = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (busy_w[i] !== 1'b1) $display("FAIL busy_in_run inst%0d: got %b expected 1", i, busy_w[i]);
      else n_pass++;
    end
    @(negedge clk) up_done = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 2300 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      up_done = 1'b0;
      if (spur_at > 0 && cyc - tc == spur_at) begin
        start = 1'b1;
        up_done = 1'b1;
      end
      if (abort_at > 0 && cyc - tc == abort_at) begin
        n_total++;
        if (upa_w[0] !== 32'(abort_at)) $display("FAIL abort_addr: got %0d expected %0d", upa_w[0], abort_at);
        else n_pass++;
        run_active = 1'b0;
        resetn = 1'b0;
        return;
      end
      fin = 1'b1;
      for (int i = 0; i < N; i++) if (done_cnt[i] == b_done[i]) fin = 1'b0;
    end
    run_active = 1'b0;
    n_total++;
    if (!fin) $display("FAIL done_timeout: got no done expected done within 2300 cycles");
    else n_pass++;
    #1;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (done_cyc[i] - tc !== 2049 + i + 1)
        $display("FAIL done_latency inst%0d: got %0d expected %0d", i, done_cyc[i] - tc, 2050 + i);
      else n_pass++;
      n_total++;
      if (done_cnt[i] - b_done[i] !== 1 || done_w[i] !== 1'b0 || busy_w[i] !== 1'b0)
        $display("FAIL done_pulse inst%0d: got cycles=%0d done=%b busy=%b expected 1/0/0",
                 i, done_cnt[i] - b_done[i], done_w[i], busy_w[i]);
      else n_pass++;
      n_total++;
      if (ups_cnt[i] - b_ups[i] !== 1)
        $display("FAIL up_start_count inst%0d: got %0d expected 1", i, ups_cnt[i] - b_ups[i]);
      else n_pass++;
      n_total++;
      if (addr_err[i] - b_err[i] !== 0)
        $display("FAIL addr_sequence inst%0d: got %0d bad addresses expected 0", i, addr_err[i] - b_err[i]);
      else n_pass++;
    end
    n_total++;
    if (exp_q.size() !== 128) $display("FAIL scoreboard_depth: got %0d expected 128", exp_q.size());
    else n_pass++;
    for (int ch = 0; ch < 128 && exp_q.size() > 0; ch++) begin
      e = exp_q.pop_front();
      read_addr = 32'(ch);
      #1;
      for (int i = 0; i < N; i++) begin
        n_total++;
        if (rd_w[i] !== 4'(e)) $display("FAIL result ch%0d inst%0d: got %0d expected %0d", ch, i, rd_w[i], e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || ups_w[i] !== 1'b0 || upa_w[i] !== 32'd0)
        $display("FAIL reset_outputs inst%0d: got done=%b busy=%b up_start=%b addr=%0d expected all 0",
                 i, done_w[i], busy_w[i], ups_w[i], upa_w[i]);
      else n_pass++;
    end
    read_addr = 32'd127;
    #1;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (rd_w[i] !== 4'd0) $display("FAIL reset_read inst%0d: got %0d expected 0", i, rd_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_const15();
    for (int a = 0; a < N_ELEM; a++) up_mem[a] = 4'd15;
    for (int ch = 0; ch < 128; ch++) exp_q.push_back(15);
    do_run(0, 0);
  endtask

  task automatic test_ramp();
    for (int a = 0; a < N_ELEM; a++) up_mem[a] = 4'(a % 16);
    for (int ch = 0; ch < 128; ch++) exp_q.push_back(8);
    do_run(0, 0);
  endtask

  task automatic test_round();
    for (int a = 0; a < N_ELEM; a++) up_mem[a] = 4'($urandom_range(0, 15));
    for (int j = 0; j < 16; j++) begin
      up_mem[0*16 + j] = 4'd1;
      up_mem[1*16 + j] = 4'd1;
      up_mem[2*16 + j] = (j == 0) ? 4'd7 : 4'd0;
      up_mem[3*16 + j] = (j == 0) ? 4'd8 : 4'd0;
    end
    up_mem[5]  = 4'd9;
    up_mem[16] = 4'd8;
    exp_q.push_back(2);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int ch = 4; ch < 128; ch++) exp_q.push_back(exp_avg(ch));
    do_run(0, 0);
  endtask

  task automatic test_spurious();
    for (int a = 0; a < N_ELEM; a++) up_mem[a] = 4'($urandom_range(0, 15));
    push_expected();
    do_run(500, 0);
  endtask

  task automatic test_reset_midrun();
    int nz;
    for (int a = 0; a < N_ELEM; a++) up_mem[a] = 4'($urandom_range(0, 15));
    do_run(0, 1000);
    #1;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (busy_w[i] !== 1'b0 || upa_w[i] !== 32'd0 || done_w[i] !== 1'b0)
        $display("FAIL abort_outputs inst%0d: got busy=%b addr=%0d done=%b expected 0/0/0",
                 i, busy_w[i], upa_w[i], done_w[i]);
      else n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      nz = 0;
      for (int ch = 0; ch < 128; ch++) begin
        read_addr = 32'(ch);
        #1;
        if (rd_w[i] !== 4'd0) nz++;
      end
      n_total++;
      if (nz !== 0) $display("FAIL abort_clear inst%0d: got %0d nonzero entries expected 0", i, nz);
      else n_pass++;
    end
    @(negedge clk) resetn = 1'b1;
    push_expected();
    do_run(0, 0);
  endtask

  task automatic test_read_oob();
    logic [31:0] addrs [3];
    addrs[0] = 32'd200;
    addrs[1] = 32'd128;
    addrs[2] = 32'h0001_0005;
    for (int k = 0; k < 3; k++) begin
      read_addr = addrs[k];
      #1;
      for (int i = 0; i < N; i++) begin
        n_total++;
        if (rd_w[i] !== 4'd0) $display("FAIL read_oob addr=%0h inst%0d: got %0d expected 0", addrs[k], i, rd_w[i]);
        else n_pass++;
      end
    end
    read_addr = 32'd5;
    #1;
    for (int i = 0; i < N; i++) begin
      n_total++;
      if (rd_w[i] !== 4'(exp_avg(5))) $display("FAIL read_inrange inst%0d: got %0d expected %0d", i, rd_w[i], exp_avg(5));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_const15();
    test_ramp();
    test_round();
    test_spurious();
    test_reset_midrun();
    test_read_oob();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
